// File: rtl/rr_stream_mux.sv
// rr_stream_mux: round-robin arbiter merging NUM_REQ valid/ready streams into
// one output stream through a 2-entry queue. Input ready is derived only from
// registered occupancy, so consumer backpressure never reaches req_ready_o
// combinationally.
module rr_stream_mux #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [$clog2(NUM_REQ)-1:0]    out_index_o,
  input  logic                          out_ready_i
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Queue occupancy; FULL blocks new pushes even when a pop happens the same cycle.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e                  occ_q, occ_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      head_idx_q, head_idx_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic [IDX_W-1:0]      tail_idx_q, tail_idx_d;
  logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;

  logic                  found;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      cand_idx;
  int unsigned           cand;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  accept;
  logic                  push;
  logic                  pop;

  assign accept = (occ_q != OCC_FULL);

  // Rotating priority search starting at ptr; first valid requester wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(ptr_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_valid_i[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  // One-hot ready for the winner; reset gates it directly as well as via accept.
  always_comb begin
    grant         = '0;
    grant[winner] = 1'b1;
    req_ready_o   = grant & {NUM_REQ{found & accept & arst_ni}};
    win_data      = req_data_i[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign push = found & accept & arst_ni;
  assign pop  = out_valid_o & out_ready_i;

  // Queue, occupancy and round-robin pointer next-state.
  always_comb begin
    occ_d       = occ_q;
    ptr_d       = ptr_q;
    head_idx_d  = head_idx_q;
    head_data_d = head_data_q;
    tail_idx_d  = tail_idx_q;
    tail_data_d = tail_data_q;

    if (push) begin
      ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
    end

    unique case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          head_idx_d  = winner;
          head_data_d = win_data;
          occ_d       = OCC_ONE;
        end
      end
      OCC_ONE: begin
        // Simultaneous push/pop: the new entry goes straight into the head slot.
        if (push && pop) begin
          head_idx_d  = winner;
          head_data_d = win_data;
        end else if (push) begin
          tail_idx_d  = winner;
          tail_data_d = win_data;
          occ_d       = OCC_FULL;
        end else if (pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          head_idx_d  = tail_idx_q;
          head_data_d = tail_data_q;
          occ_d       = OCC_ONE;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  // State registers; asynchronous reset discards all queued entries.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      occ_q       <= OCC_EMPTY;
      ptr_q       <= '0;
      head_idx_q  <= '0;
      head_data_q <= '0;
      tail_idx_q  <= '0;
      tail_data_q <= '0;
    end else begin
      occ_q       <= occ_d;
      ptr_q       <= ptr_d;
      head_idx_q  <= head_idx_d;
      head_data_q <= head_data_d;
      tail_idx_q  <= tail_idx_d;
      tail_data_q <= tail_data_d;
    end
  end

  // Head presentation; outputs read zero rather than stale contents when empty.
  always_comb begin
    out_valid_o = (occ_q != OCC_EMPTY);
    out_data_o  = out_valid_o ? head_data_q : '0;
    out_index_o = out_valid_o ? head_idx_q  : '0;
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: a rotation-search model predicts grants
// and queued entries; a separate monitor checks the output stream.
module tb_rr_stream_mux;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk;
  logic            arst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_index;
  logic            out_ready;

  typedef struct packed {
    logic [1:0]    idx;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          exp_q[$];
  int            model_ptr;
  int            total;
  int            bad;
  logic [DW-1:0] din[N];
  bit            fixed_data;

  rr_stream_mux #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .arst_ni     (arst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_index_o (out_index),
    .out_ready_i (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid requester when searching ptr, ptr+1, ... with wrap.
  function automatic int model_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One cycle: drive at negedge, check predicted ready, apply acceptance at posedge.
  task automatic step(input logic [N-1:0] v, input logic ordy);
    int         w;
    logic [N-1:0] er;
    @(negedge clk);
    req_valid = v;
    out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      din[i] = fixed_data ? DW'(16 + i) : {$urandom, $urandom};
      req_data[i*DW +: DW] = din[i];
    end
    #1;
    w  = model_winner(v, model_ptr);
    er = '0;
    if (arst_n && exp_q.size() < 2 && w >= 0) er[w] = 1'b1;
    chk("req_ready", DW'(req_ready), DW'(er));
    @(posedge clk);
    if (er != '0) begin
      exp_q.push_back(ent_t'{idx: 2'(w), data: din[w]});
      model_ptr = (w + 1) % N;
    end
  endtask

  // Output monitor: compares the head against the scoreboard every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) begin
        chk("out_valid_idle", DW'(out_valid), DW'(0));
        chk("out_data_idle", out_data, '0);
        chk("out_index_idle", DW'(out_index), DW'(0));
      end else begin
        chk("out_valid", DW'(out_valid), DW'(1));
        chk("out_index", DW'(out_index), DW'(exp_q[0].idx));
        chk("out_data", out_data, exp_q[0].data);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    total      = 0;
    bad        = 0;
    model_ptr  = 0;
    fixed_data = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    out_ready  = 1'b0;
    arst_n     = 1'b1;
    #1 arst_n  = 1'b0;

    // Reset held with everyone valid: no ready, idle outputs.
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    #1 arst_n = 1'b1;

    // Fair rotation with fixed payloads 0x10+i.
    for (int i = 0; i < 9; i++) step(4'hF, 1'b1);
    for (int i = 0; i < 3; i++) step(4'h0, 1'b1);

    // Sparse requesters 1 and 3 with wrap back to 1.
    for (int i = 0; i < 4; i++) step(4'b1010, 1'b1);
    for (int i = 0; i < 3; i++) step(4'h0, 1'b1);

    // Backpressure: two accepts, stall, single pop, next accept one cycle later.
    for (int i = 0; i < 4; i++) step(4'hF, 1'b0);
    step(4'hF, 1'b1);
    step(4'hF, 1'b0);
    step(4'hF, 1'b0);
    for (int i = 0; i < 4; i++) step(4'h0, 1'b1);

    // Withdrawal: requester 2 drops out while full, requester 3 gets the slot.
    fixed_data = 1'b0;
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    step(4'b1100, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    for (int i = 0; i < 4; i++) step(4'h0, 1'b1);

    // Reset mid-cycle with a full queue.
    for (int i = 0; i < 3; i++) step(4'hF, 1'b0);
    @(negedge clk);
    #3 arst_n = 1'b0;
    #1;
    chk("midrst_out_valid", DW'(out_valid), DW'(0));
    chk("midrst_out_data", out_data, '0);
    chk("midrst_req_ready", DW'(req_ready), DW'(0));
    exp_q.delete();
    model_ptr = 0;
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    #1 arst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(4'hF, 1'b1);

    // Randomized traffic and backpressure.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) step(4'h0, 1'b1);
    chk("final_out_valid", DW'(out_valid), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Multiplexes NUM_REQ independent valid/ready request streams onto a single output stream using round-robin arbitration, buffering winners in a 2-entry output queue. It sits directly downstream of the requesters and upstream of a shared consumer such as a shared port or execution unit. The block decouples the consumer's `out_ready_i` from all `req_ready_o` paths, so no combinational path exists from output backpressure to input ready.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `DATA_WIDTH`, default 64: payload width per request.

- `clk_i`  input  1  clock, rising edge.
- `arst_ni`  input  1  asynchronous reset, active low.
- `req_valid_i`  input  NUM_REQ  per-requester valid.
- `req_data_i`  input  NUM_REQ×DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready_o`  output  NUM_REQ  per-requester ready; one-hot or zero.
- `out_valid_o`  output  1  output queue head valid.
- `out_data_o`  output  DATA_WIDTH  head payload.
- `out_index_o`  output  $clog2(NUM_REQ)  requester index of the head entry.
- `out_ready_i`  input  1  consumer ready.

## Operation
- **Transfers.**
  - An input transfer on requester i happens when `req_valid_i[i] & req_ready_o[i]`.
  - An output transfer happens when `out_valid_o & out_ready_i`.
- **State.**
  - Round-robin pointer `ptr` of width $clog2(NUM_REQ).
  - 2-entry FIFO holding {index, data}.
  - Occupancy counter `count`, 0..2.
- **Accept enable.** `accept = (count != 2)`. It uses only registered state. A pop in the same cycle does NOT free a slot for a push while full.
- **Arbitration**, combinational, evaluated every cycle:
  - Search requesters in order ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  - The winner is the first requester with `req_valid_i` set.
  - `req_ready_o = accept ? onehot(winner) : '0`.
  - `req_ready_o` is zero when no requester is valid.
- **Pointer update.** On an input transfer by winner w, `ptr <= (w+1) mod NUM_REQ`. Otherwise `ptr` holds. Wrap: w = NUM_REQ-1 gives ptr = 0.
- **Push.** An input transfer writes {w, req_data_i[w]} at the FIFO tail.
- **Pop.** An output transfer removes the head.
- **Counter update.**
  - push only: `count + 1`.
  - pop only: `count - 1`.
  - push and pop together: unchanged.
  - Push and pop together is only possible at count = 1. The new entry becomes head next cycle.
- **Output signals.**
  - `out_valid_o = (count != 0)`.
  - `out_data_o` and `out_index_o` reflect the head.
  - When count = 0 they are driven to 0, not to stale values.
- **Ordering and payload.** Output order is strictly acceptance order. The payload is never modified.
- **Fairness.** With all requesters continuously valid and no backpressure, grants cycle through 0,1,…,NUM_REQ-1,0,…. A requester waits at most NUM_REQ-1 accepted transfers after becoming valid.
- **Requester rules.**
  - Requesters may withdraw `req_valid_i` before acceptance.
  - The block holds no state per requester apart from `ptr`.

## Timing
- **Reset** (asynchronous assert, synchronous-safe release):
  - ptr = 0, count = 0.
  - out_valid_o = 0, out_data_o = 0, out_index_o = 0.
  - req_ready_o = 0 while `arst_ni` is low. req_ready_o is gated by reset directly, not only through `accept`.
- **Reset mid-operation.** All queued entries are discarded. No output transfer may be reported after reset asserts.
- **Latency.** Data accepted at edge t is on `out_data_o` with `out_valid_o` = 1 after edge t, when the queue was empty. There is no combinational input→output path.
- **Throughput.** One transfer per cycle sustained while the consumer is always ready, with count steady at 1.
- **Backpressure.**
  - With `out_ready_i` = 0, at most 2 entries are accepted.
  - `req_ready_o` then drops to 0 in the cycle after count reaches 2.
  - Accepting resumes the cycle after the first pop.
- **Stability.** `req_ready_o` depends combinationally on `req_valid_i`, `ptr`, and `count` only. It never depends on `out_ready_i`.

## Test plan
- **Reset.**
  - Stimulus: hold `arst_ni` low with all requesters valid.
  - Required: req_ready_o = 0, out_valid_o = 0, out_data_o = 0.
  - Stimulus: release reset.
  - Required: the first grant is requester 0, and out_index_o = 0 on the next cycle.
- **Fair rotation.**
  - Stimulus: NUM_REQ = 4, all valid, out_ready_i = 1, data_i = 0x10+i, run 8 cycles.
  - Required: out_index_o sequence 0,1,2,3,0,1,2,3 with data 0x10,0x11,0x12,0x13,… and one output per cycle after the first.
- **Sparse and wrap-around.**
  - Stimulus: only requesters 1 and 3 valid.
  - Required: grant sequence 1,3,1,3. After a grant to 3, ptr = 0 and the next winner is 1.
- **Backpressure and full.**
  - Stimulus: out_ready_i = 0, all valid.
  - Required: exactly 2 accepts (indices 0, 1), then req_ready_o = 0.
  - Stimulus: raise out_ready_i for 1 cycle.
  - Required: head 0 pops, and index 2 is accepted in the following cycle, not the same cycle.
- **Withdrawal.**
  - Stimulus: requester 2 valid while the queue is full, then deasserted before space frees; requester 3 valid.
  - Required: 3 is granted and 2 never appears at the output.
- **Reset mid-operation.**
  - Stimulus: fill the queue (count = 2), assert `arst_ni` asynchronously mid-cycle.
  - Required: out_valid_o falls immediately, and after release the queue is empty with ptr = 0.
